scmp_bus_if: RTL

- Downstream bus-interface stage for the scmp core.
- Demultiplexes the core's address-strobe cycle: it latches A15:12 and the cycle flags (H,D,I,R), which the core drives on D_o while ADS_n is low.
- Converts the core's RD_n/WR_n strobes into a req/ack handshake to a synchronous memory or peripheral fabric.
- Returns read data on the core's D_i, and flags protocol violations (strobe ended early, memory timeout).

---
 rtl/scmp_bus_if.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/scmp_bus_if.sv
// scmp_bus_if: downstream bus-interface stage for the scmp core.
// Demultiplexes the address-strobe cycle (A15:12 and cycle flags on D_o),
// turns RD_n/WR_n strobes into a level req / single-cycle ack handshake,
// returns read data on cpu_D_i and flags strobe-protocol and timeout errors.
module scmp_bus_if #(
    parameter int          MAX_WAIT  = 15,     // 1..255 cycles of mem_req without mem_ack
    parameter logic [7:0]  IDLE_DATA = 8'hFF   // idle bus value, also returned on timeout
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_D_o,
    input  logic        cpu_ADS_n,
    input  logic        cpu_RD_n,
    input  logic        cpu_WR_n,
    output logic [7:0]  cpu_D_i,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [3:0]  cyc_flags,
    input  logic        err_clr,
    output logic        late_err,
    output logic        tmo_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    // Last count value at which a missing ack still leaves room to wait;
    // sampling no ack here makes the counter reach MAX_WAIT (timeout).
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        RD_WAIT = 3'd2,
        RD_DONE = 3'd3,
        WR_WAIT = 3'd4,
        WR_DONE = 3'd5
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   wait_cnt_reg;
    logic [15:0]     mem_addr_reg;
    logic [7:0]      mem_wdata_reg;
    logic [3:0]      cyc_flags_reg;
    logic            mem_req_reg;
    logic            mem_we_reg;
    logic [7:0]      rdata_reg;      // read data held for the core during RD_DONE
    logic            late_err_reg;
    logic            tmo_err_reg;

    logic [15:0]     cap_addr;
    logic            strobe_low;
    logic            wait_end;

    // Full address and the strobe belonging to the outstanding request.
    assign cap_addr   = {cpu_D_o[3:0], cpu_addr};
    assign strobe_low = (state_reg == RD_WAIT) ? ~cpu_RD_n : ~cpu_WR_n;
    assign wait_end   = mem_ack || (wait_cnt_reg == WAIT_LAST);

    // Bus FSM: address capture, request/ack handshake, sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cyc_flags_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            rdata_reg     <= IDLE_DATA;
            late_err_reg  <= 1'b0;
            tmo_err_reg   <= 1'b0;
        end else begin
            // Clear first; any set below in the same cycle overrides it.
            if (err_clr) begin
                late_err_reg <= 1'b0;
                tmo_err_reg  <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!cpu_ADS_n) begin
                        mem_addr_reg  <= cap_addr;
                        cyc_flags_reg <= cpu_D_o[7:4];
                        state_reg     <= ADDR;
                    end
                end

                ADDR: begin
                    if (!cpu_ADS_n) begin
                        // Stretched ADS_n keeps re-capturing; last value wins.
                        mem_addr_reg  <= cap_addr;
                        cyc_flags_reg <= cpu_D_o[7:4];
                    end else if (!cpu_RD_n) begin
                        if (!cpu_WR_n) begin
                            late_err_reg <= 1'b1;
                        end
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= RD_WAIT;
                    end else if (!cpu_WR_n) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b1;
                        mem_wdata_reg <= cpu_D_o;
                        wait_cnt_reg  <= '0;
                        state_reg     <= WR_WAIT;
                    end
                end

                RD_WAIT, WR_WAIT: begin
                    // A new address strobe while busy is a protocol error; the
                    // address is dropped and the outstanding request continues.
                    if (!cpu_ADS_n) begin
                        late_err_reg <= 1'b1;
                    end
                    // Counter never exceeds MAX_WAIT: it leaves this state at
                    // WAIT_LAST at the latest, so the increment saturates there.
                    wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    if (wait_end) begin
                        mem_req_reg <= 1'b0;
                        if (!mem_ack) begin
                            tmo_err_reg <= 1'b1;
                        end
                        if (state_reg == RD_WAIT) begin
                            rdata_reg <= mem_ack ? mem_rdata : IDLE_DATA;
                        end
                        if (strobe_low) begin
                            state_reg <= (state_reg == RD_WAIT) ? RD_DONE : WR_DONE;
                        end else begin
                            late_err_reg <= 1'b1;
                            state_reg    <= IDLE;
                        end
                    end
                end

                RD_DONE, WR_DONE: begin
                    if (!cpu_ADS_n) begin
                        mem_addr_reg  <= cap_addr;
                        cyc_flags_reg <= cpu_D_o[7:4];
                        state_reg     <= ADDR;
                    end else if ((state_reg == RD_DONE) ? cpu_RD_n : cpu_WR_n) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Read data mux: zero-latency bypass in the ack cycle, held data after.
    always_comb begin
        cpu_D_i = IDLE_DATA;
        if (state_reg == RD_WAIT && mem_ack) begin
            cpu_D_i = mem_rdata;
        end else if (state_reg == RD_DONE) begin
            cpu_D_i = rdata_reg;
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign cyc_flags = cyc_flags_reg;
    assign late_err  = late_err_reg;
    assign tmo_err   = tmo_err_reg;

endmodule
